fp32_sqrt_result_stage: RTL
===========================

# fp32_sqrt_result_stage

Registered result stage directly downstream of the combinational FP32 square-root datapath. It captures each result word and its five IEEE-754 exception flags into a small FIFO and presents them on a valid/ready output. On retirement it folds the flags into a sticky, CSR-style exception register. It breaks the long combinational sqrt path and provides back-pressure between the sqrt datapath and the writeback/consumer logic.

## Interface
- DEPTH, 2: FIFO entries; power of two, 2..8.
- TAG_W, 4: width of the opaque request tag carried alongside each result.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous discard of all buffered results.
- in_valid  in  1  sqrt result present this cycle.
- in_ready  out  1  stage can accept a result this cycle.
- in_y  in  32  IEEE-754 single result word from the sqrt datapath.
- in_exc  in  5  flags {invalid, divzero, overflow, underflow, inexact}, bit 4..0.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_y  out  32  head result word.
- out_exc  out  5  head exception flags.
- out_tag  out  TAG_W  head tag.
- count  out  $clog2(DEPTH)+1  occupancy.
- fflags  out  5  sticky accumulated exception flags, same bit order as in_exc.
- fflags_clr  in  1  clear the sticky flags.

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count < DEPTH) & !flush. There is no combinational path from out_ready. When the FIFO is full, a same-cycle pop does not enable a push.
- The FIFO is circular, with rd_ptr/wr_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH. Entries are {y, exc, tag}.
- count_next = count + push - pop. Push and pop in the same cycle leave count unchanged.
- out_valid = (count != 0). out_y/out_exc/out_tag are driven from the entry at rd_ptr. They are 0 when empty.
- flush: pointers and count go to 0 next cycle, and any same-cycle push is blocked via in_ready. A same-cycle pop still counts as retired for fflags. fflags are otherwise unaffected.
- Sticky flags: fflags_next = (fflags_clr ? 5'b0 : fflags) | (pop ? out_exc : 5'b0). Clear and retire in the same cycle therefore leave exactly the retiring flags.
- Flags accumulate only on retirement (pop), never on push. A flushed entry never contributes.
- Data is not inspected. NaN, infinity and zero words pass unchanged. divzero is passed through and accumulated like any other flag.
- Push and pop are qualified by their valid signals only. Data inputs are don't-care when in_valid=0.

## Timing
- Latency: a result pushed in cycle N appears on out_* in cycle N+1 if the FIFO was empty. Otherwise it appears after the preceding entries retire.
- Throughput is 1 result/cycle while not full. With DEPTH=2 and out_ready held high, a continuous stream sustains full rate.
- Reset, in the cycle after rst is sampled high:
  - count=0, pointers=0, out_valid=0, out_y=0, out_exc=0, out_tag=0, fflags=0.
  - in_ready=1 unless flush is asserted.
- rst mid-stream discards all entries and fflags. rst has priority over flush, fflags_clr, push and pop.
- The out_* outputs of a valid head are stable while out_ready=0. The consumer may rely on this.

## Configuration
- FP32_SQRT_FFLAGS_EN defined: sticky accumulator present as described.
- Not defined: fflags is tied to 5'b0, fflags_clr is ignored, and no flag register is built. Per-entry out_exc is still buffered and presented.

## Structure
- Shared package fp32_pkg:
  - exc_t as a packed struct {invalid, divzero, overflow, underflow, inexact}.
  - Flag bit-index constants EXC_NV=4, EXC_DZ=3, EXC_OF=2, EXC_UF=1, EXC_NX=0.
  - Canonical NaN constant 32'h7fc00000.
- One sub-module, fp32_res_fifo: generic sync FIFO parameterised on width and depth, with the flush port. The top adds the sticky flag logic and the port packing.

## Test plan
- Reset, then one push: in_y=32'h3fb504f3, in_exc=5'b00001, tag=3 → out_valid in the next cycle with identical fields. Pop → fflags=5'b00001, count=0.
- Fill with out_ready=0: after DEPTH pushes, in_ready=0 and count=DEPTH. Assert in_valid and out_ready together while full → only a pop occurs, and in_ready rises in the next cycle.
- Stream 16 results with out_ready=1 → in-order output, full rate, pointer wrap correct, count never exceeds 1.
- Retire 32'h7fc00000 with exc=5'b10000 while fflags_clr=1 → fflags=5'b10000. Then retire a result with exc=5'b00001 → fflags=5'b10001.
- Two entries buffered, flush=1 with in_valid=1 and out_ready=1 → head retires into fflags, the push is dropped, and count=0 in the next cycle.
- Assert rst with 2 entries and fflags=5'b00101 → all outputs 0 in the next cycle. Build without FP32_SQRT_FFLAGS_EN → fflags stays 0 across retirements carrying non-zero flags.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: exception flag layout, bit indices and the canonical NaN.
package fp32_pkg;

  localparam int EXC_NV = 4;
  localparam int EXC_DZ = 3;
  localparam int EXC_OF = 2;
  localparam int EXC_UF = 1;
  localparam int EXC_NX = 0;

  localparam logic [31:0] CANON_NAN = 32'h7fc00000;

  typedef struct packed {
    logic invalid;
    logic divzero;
    logic overflow;
    logic underflow;
    logic inexact;
  } exc_t;

endpackage

// File: rtl/fp32_res_fifo.sv
// Generic circular sync FIFO with synchronous flush; read data reads as zero while empty.
module fp32_res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // A full FIFO refuses the push even if the head retires this cycle.
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fp32_sqrt_result_stage.sv
// Registered result stage behind the FP32 sqrt datapath: result FIFO plus sticky fflags.
// Define FP32_SQRT_FFLAGS_EN to build the sticky exception accumulator.
module fp32_sqrt_result_stage
  import fp32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_y,
  input  logic [4:0]             in_exc,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_y,
  output logic [4:0]             out_exc,
  output logic [TAG_W-1:0]       out_tag,
  output logic [$clog2(DEPTH):0] count,
  output logic [4:0]             fflags,
  input  logic                   fflags_clr
);

  localparam int EW = 32 + 5 + TAG_W;

  logic          push, pop, full, empty;
  logic [EW-1:0] rdata;
  exc_t          head_exc;

  // in_ready depends only on occupancy and flush, never on out_ready.
  assign in_ready  = ~full & ~flush;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  fp32_res_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_y, in_exc, in_tag}),
    .rdata_o (rdata),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign {out_y, head_exc, out_tag} = rdata;
  assign out_exc = head_exc;

`ifdef FP32_SQRT_FFLAGS_EN
  logic [4:0] fflags_q, fflags_d;

  // Retirement wins over clear, so clear+pop leaves exactly the retiring flags.
  always_comb begin
    fflags_d = (fflags_clr ? 5'b0 : fflags_q) | (pop ? head_exc : 5'b0);
  end

  always_ff @(posedge clk) begin
    if (rst) fflags_q <= '0;
    else     fflags_q <= fflags_d;
  end

  assign fflags = fflags_q;
`else
  logic unused_clr;
  assign unused_clr = fflags_clr;
  assign fflags     = 5'b0;
`endif

endmodule
